// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: render-box command bus from the command decoder to the tile scheduler.
interface tile_scheduler_if;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         tiles_x;
  logic [8:0]         tiles_y;
  logic signed [31:0] w0_init;
  logic signed [31:0] w1_init;
  logic signed [31:0] w2_init;
  logic signed [18:0] A01;
  logic signed [18:0] A12;
  logic signed [18:0] A20;
  logic signed [23:0] B01;
  logic signed [23:0] B12;
  logic signed [23:0] B20;
  logic [31:0]        addr_init;
  logic [15:0]        stride;
  modport master (
    output cmd_valid, tiles_x, tiles_y, w0_init, w1_init, w2_init,
           A01, A12, A20, B01, B12, B20, addr_init, stride,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, tiles_x, tiles_y, w0_init, w1_init, w2_init,
           A01, A12, A20, B01, B12, B20, addr_init, stride,
    output cmd_ready
  );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a box of tiles through raster and write-out, overlapping raster of the next tile with the drain of the last.
module tile_scheduler #(
  parameter int TILE_LOG2      = 5,
  parameter int PIX_BYTES_LOG2 = 1
) (
  input  logic                gpu_clk,
  input  logic                gpu_resetn,
  tile_scheduler_if.slave     cmd,
  input  logic                abort,
  output logic [31:0]         w0_out,
  output logic [31:0]         w1_out,
  output logic [31:0]         w2_out,
  output logic [31:0]         wr_addr_out,
  output logic                tile_start,
  input  logic                tile_done,
  output logic                write_start,
  input  logic                writer_reading,
  input  logic                writer_flushed,
  output logic                busy,
  output logic                box_done,
  output logic [15:0]         tiles_written
);
  typedef enum logic [2:0] {IDLE, RASTER, RWAIT, ADV, FLUSH, FIN} state_t;
  localparam logic [31:0] X_STEP = 32'd1 << (TILE_LOG2 + PIX_BYTES_LOG2);
  state_t           state_q, state_d;
  logic             guard_q, guard_d;
  logic             abort_pend_q, abort_pend_d;
  logic             tile_start_q, tile_start_d;
  logic             write_start_q, write_start_d;
  logic             box_done_q, box_done_d;
  logic [8:0]       tx_q, tx_d, ty_q, ty_d, col_q, col_d, row_q, row_d;
  logic [2:0][31:0] w_q, w_d, wr_q, wr_d, ax_q, ax_d, by_q, by_d;
  logic [31:0]      addr_q, addr_d, row_addr_q, row_addr_d, y_step_q, y_step_d;
  logic [15:0]      tw_q, tw_d;
  always_comb begin
    state_d       = state_q;
    abort_pend_d  = abort_pend_q;
    tile_start_d  = 1'b0;
    write_start_d = 1'b0;
    box_done_d    = 1'b0;
    tx_d          = tx_q;
    ty_d          = ty_q;
    col_d         = col_q;
    row_d         = row_q;
    w_d           = w_q;
    wr_d          = wr_q;
    ax_d          = ax_q;
    by_d          = by_q;
    addr_d        = addr_q;
    row_addr_d    = row_addr_q;
    y_step_d      = y_step_q;
    tw_d          = tw_q;
    unique case (state_q)
      IDLE: if (cmd.cmd_valid) begin
        tx_d         = cmd.tiles_x;
        ty_d         = cmd.tiles_y;
        w_d          = {cmd.w2_init, cmd.w1_init, cmd.w0_init};
        wr_d         = {cmd.w2_init, cmd.w1_init, cmd.w0_init};
        // Steps are widened with sign before the tile shift; 19+5 and 24+5 bits fit in 32.
        ax_d         = {32'(cmd.A20) << TILE_LOG2, 32'(cmd.A12) << TILE_LOG2, 32'(cmd.A01) << TILE_LOG2};
        by_d         = {32'(cmd.B20) << TILE_LOG2, 32'(cmd.B12) << TILE_LOG2, 32'(cmd.B01) << TILE_LOG2};
        addr_d       = cmd.addr_init;
        row_addr_d   = cmd.addr_init;
        y_step_d     = 32'(cmd.stride) << TILE_LOG2;
        col_d        = '0;
        row_d        = '0;
        tw_d         = '0;
        abort_pend_d = 1'b0;
        state_d      = (cmd.tiles_x == '0 || cmd.tiles_y == '0) ? FIN : RASTER;
      end
      RASTER: if (abort) state_d = FLUSH;
        else if (tile_done) begin
        tile_start_d = 1'b1;
        state_d      = RWAIT;
      end
      RWAIT: begin
        // An abort here only stops the walk once the in-flight tile has been handed to the writer.
        abort_pend_d = abort_pend_q | abort;
        if (!guard_q && tile_done && !writer_reading) begin
          write_start_d = 1'b1;
          tw_d          = tw_q + 16'd1;
          state_d       = (abort_pend_q | abort) ? FLUSH : ADV;
        end
      end
      ADV: if (abort) state_d = FLUSH;
        else if (col_q != tx_q - 9'd1) begin
        col_d   = col_q + 9'd1;
        for (int i = 0; i < 3; i++) w_d[i] = w_q[i] + ax_q[i];
        addr_d  = addr_q + X_STEP;
        state_d = RASTER;
      end else if (row_q != ty_q - 9'd1) begin
        col_d      = '0;
        row_d      = row_q + 9'd1;
        for (int i = 0; i < 3; i++) begin
          wr_d[i] = wr_q[i] + by_q[i];
          w_d[i]  = wr_q[i] + by_q[i];
        end
        row_addr_d = row_addr_q + y_step_q;
        addr_d     = row_addr_q + y_step_q;
        state_d    = RASTER;
      end else state_d = FLUSH;
      FLUSH: if (!guard_q && writer_flushed && !writer_reading) state_d = FIN;
      FIN: begin
        box_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    guard_d = state_d != state_q;
  end
  always_ff @(posedge gpu_clk or negedge gpu_resetn)
    if (!gpu_resetn) begin
      state_q       <= IDLE;
      guard_q       <= 1'b0;
      abort_pend_q  <= 1'b0;
      tile_start_q  <= 1'b0;
      write_start_q <= 1'b0;
      box_done_q    <= 1'b0;
      tx_q          <= '0;
      ty_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      w_q           <= '0;
      wr_q          <= '0;
      ax_q          <= '0;
      by_q          <= '0;
      addr_q        <= '0;
      row_addr_q    <= '0;
      y_step_q      <= '0;
      tw_q          <= '0;
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      abort_pend_q  <= abort_pend_d;
      tile_start_q  <= tile_start_d;
      write_start_q <= write_start_d;
      box_done_q    <= box_done_d;
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      col_q         <= col_d;
      row_q         <= row_d;
      w_q           <= w_d;
      wr_q          <= wr_d;
      ax_q          <= ax_d;
      by_q          <= by_d;
      addr_q        <= addr_d;
      row_addr_q    <= row_addr_d;
      y_step_q      <= y_step_d;
      tw_q          <= tw_d;
    end
  assign cmd.cmd_ready   = state_q == IDLE;
  assign busy            = state_q != IDLE;
  assign tile_start      = tile_start_q;
  assign write_start     = write_start_q;
  assign box_done        = box_done_q;
  assign w0_out          = w_q[0];
  assign w1_out          = w_q[1];
  assign w2_out          = w_q[2];
  assign wr_addr_out     = addr_q;
  assign tiles_written   = tw_q;
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: directed and random boxes against a closed-form tile model, with renderer/writer responders.
module tb_tile_scheduler;
  logic gpu_clk = 1'b0;
  logic gpu_resetn = 1'b0;
  always #5 gpu_clk = ~gpu_clk;
  tile_scheduler_if cmd_if();
  logic        abort = 1'b0, tile_done = 1'b1, writer_reading = 1'b0, writer_flushed = 1'b1;
  logic [31:0] w0_out, w1_out, w2_out, wr_addr_out;
  logic        tile_start, write_start, busy, box_done;
  logic [15:0] tiles_written;
  tile_scheduler dut (
    .gpu_clk(gpu_clk), .gpu_resetn(gpu_resetn), .cmd(cmd_if), .abort(abort),
    .w0_out(w0_out), .w1_out(w1_out), .w2_out(w2_out), .wr_addr_out(wr_addr_out),
    .tile_start(tile_start), .tile_done(tile_done), .write_start(write_start),
    .writer_reading(writer_reading), .writer_flushed(writer_flushed),
    .busy(busy), .box_done(box_done), .tiles_written(tiles_written)
  );
  typedef struct packed {logic [31:0] a, w0, w1, w2;} ev_t;
  ev_t ts_q[$], ws_q[$];
  int  ts_cyc[$], ws_cyc[$];
  int  checks = 0, errors = 0, cyc = 0, ts_n = 0, ws_n = 0, abort_at = 0;
  int  rlat = 3, rcnt = 0, rd_len = 2, first_rd = 0, wcnt = 0, fcnt = 0;
  bit  abort_arm = 1'b0, wfirst = 1'b0;
  logic [31:0]        cur_i [3];
  logic signed [18:0] cur_a [3];
  logic signed [23:0] cur_b [3];
  logic [31:0]        cur_ai;
  logic [15:0]        cur_st;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Closed-form edge value and address of tile (c, r) from the box origin.
  function automatic logic [31:0] edge_at(input logic [31:0] wi, input logic signed [18:0] a,
                                          input logic signed [23:0] b, input int c, input int r);
    longint v;
    v = longint'(wi) + longint'(c) * longint'(a) * 32 + longint'(r) * longint'(b) * 32;
    return v[31:0];
  endfunction
  function automatic ev_t model(input int c, input int r);
    longint ad;
    ad = longint'(cur_ai) + longint'(c) * 64 + longint'(r) * longint'(cur_st) * 32;
    return {ad[31:0], edge_at(cur_i[0], cur_a[0], cur_b[0], c, r),
            edge_at(cur_i[1], cur_a[1], cur_b[1], c, r), edge_at(cur_i[2], cur_a[2], cur_b[2], c, r)};
  endfunction
  always @(negedge gpu_clk or negedge gpu_resetn)
    if (!gpu_resetn) begin
      tile_done = 1'b1;
      rcnt = 0;
    end else if (tile_start) begin
      tile_done = 1'b0;
      rcnt = rlat;
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) tile_done = 1'b1;
    end
  always @(negedge gpu_clk or negedge gpu_resetn)
    if (!gpu_resetn) begin
      writer_reading = 1'b0;
      writer_flushed = 1'b1;
      wcnt = 0;
      fcnt = 0;
    end else if (write_start) begin
      writer_reading = 1'b1;
      writer_flushed = 1'b0;
      wcnt = (wfirst && first_rd > 0) ? first_rd : rd_len;
      fcnt = wcnt + 2;
      wfirst = 1'b0;
    end else begin
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) writer_reading = 1'b0;
      end
      if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) writer_flushed = 1'b1;
      end
    end
  always @(negedge gpu_clk) begin
    cyc++;
    abort = abort_arm;
    abort_arm = 1'b0;
    if (tile_start === 1'b1) begin
      ts_n++;
      ts_q.push_back({wr_addr_out, w0_out, w1_out, w2_out});
      ts_cyc.push_back(cyc);
      chk("ts_single_outstanding", 32'(ts_n - ws_n), 1);
      chk("ts_ws_exclusive", 32'(write_start), 0);
      if (ts_n == abort_at) abort_arm = 1'b1;
    end
    if (write_start === 1'b1) begin
      ws_n++;
      ws_q.push_back({wr_addr_out, w0_out, w1_out, w2_out});
      ws_cyc.push_back(cyc);
      chk("ws_pairs_ts", 32'(ts_n - ws_n), 0);
    end
  end
  task automatic drive_cmd(input logic [8:0] tx, ty, input logic [31:0] i0, i1, i2,
                           input logic [18:0] a0, a1, a2, input logic [23:0] b0, b1, b2,
                           input logic [31:0] ai, input logic [15:0] st);
    cmd_if.tiles_x = tx; cmd_if.tiles_y = ty;
    cmd_if.w0_init = i0; cmd_if.w1_init = i1; cmd_if.w2_init = i2;
    cmd_if.A01 = a0; cmd_if.A12 = a1; cmd_if.A20 = a2;
    cmd_if.B01 = b0; cmd_if.B12 = b1; cmd_if.B20 = b2;
    cmd_if.addr_init = ai; cmd_if.stride = st;
  endtask
  task automatic run_box(input logic [8:0] tx, ty, input logic [31:0] i0, i1, i2,
                         input logic [18:0] a0, a1, a2, input logic [23:0] b0, b1, b2,
                         input logic [31:0] ai, input logic [15:0] st,
                         input int ab, input int first, input bit ghost);
    int tot, n, lat, c, r;
    ev_t e;
    tot = int'(tx) * int'(ty);
    n = (ab > 0 && ab < tot) ? ab : tot;
    cur_i = '{i0, i1, i2}; cur_a = '{a0, a1, a2}; cur_b = '{b0, b1, b2};
    cur_ai = ai; cur_st = st;
    ts_q.delete(); ws_q.delete(); ts_cyc.delete(); ws_cyc.delete();
    ts_n = 0; ws_n = 0; abort_at = ab; first_rd = first; wfirst = 1'b1;
    @(negedge gpu_clk);
    drive_cmd(tx, ty, i0, i1, i2, a0, a1, a2, b0, b1, b2, ai, st);
    cmd_if.cmd_valid = 1'b1;
    @(negedge gpu_clk);
    chk("accept_ready_low", 32'(cmd_if.cmd_ready), 0);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_tiles_written", 32'(tiles_written), 0);
    chk("accept_w0", w0_out, i0);
    chk("accept_addr", wr_addr_out, ai);
    if (ghost) begin
      drive_cmd(9'd7, 9'd7, $urandom, $urandom, $urandom, 19'($urandom), 19'($urandom), 19'($urandom),
                24'($urandom), 24'($urandom), 24'($urandom), $urandom, 16'($urandom));
      repeat (3) @(negedge gpu_clk);
    end
    cmd_if.cmd_valid = 1'b0;
    lat = 1;
    while (box_done !== 1'b1 && lat < 4000) begin
      @(negedge gpu_clk);
      lat++;
    end
    chk("box_done_seen", 32'(lat < 4000), 1);
    if (tot == 0) chk("zero_box_latency", 32'(lat), 2);
    chk("done_writer_flushed", 32'(writer_flushed), 1);
    chk("done_writer_idle", 32'(writer_reading), 0);
    chk("tiles_written", 32'(tiles_written), 32'(n));
    chk("tile_start_count", 32'(ts_n), 32'(n));
    chk("write_start_count", 32'(ws_n), 32'(n));
    for (int k = 0; k < n && k < ts_q.size() && k < ws_q.size(); k++) begin
      c = k % int'(tx);
      r = k / int'(tx);
      e = model(c, r);
      chk("ts_addr", ts_q[k].a, e.a);
      chk("ts_w0", ts_q[k].w0, e.w0);
      chk("ts_w1", ts_q[k].w1, e.w1);
      chk("ts_w2", ts_q[k].w2, e.w2);
      chk("ws_addr", ws_q[k].a, e.a);
      chk("ws_w0", ws_q[k].w0, e.w0);
      chk("ws_w1", ws_q[k].w1, e.w1);
      chk("ws_w2", ws_q[k].w2, e.w2);
    end
    @(negedge gpu_clk);
    chk("box_done_one_cycle", 32'(box_done), 0);
    chk("idle_ready", 32'(cmd_if.cmd_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("tiles_written_hold", 32'(tiles_written), 32'(n));
  endtask
  initial begin
    logic [8:0] rtx, rty;
    int ab, k;
    cmd_if.cmd_valid = 1'b0;
    drive_cmd('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge gpu_clk);
    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tile_start", 32'(tile_start), 0);
    chk("rst_write_start", 32'(write_start), 0);
    chk("rst_box_done", 32'(box_done), 0);
    chk("rst_w0", w0_out, 0);
    chk("rst_addr", wr_addr_out, 0);
    chk("rst_tiles_written", 32'(tiles_written), 0);
    gpu_resetn = 1'b1;
    rlat = 3; rd_len = 2;
    run_box(9'd2, 9'd2, 32'd100, 32'd7, -32'sd5, 19'd1, 19'd3, -19'sd4, -24'sd2, 24'd5, 24'd6,
            32'h1000, 16'd640, 0, 0, 1'b0);
    if (ws_q.size() == 4 && ts_q.size() == 4) begin
      chk("t1_addr1", ws_q[1].a, 32'h1040);
      chk("t1_addr2", ws_q[2].a, 32'h6000);
      chk("t1_addr3", ws_q[3].a, 32'h6040);
      chk("t1_w0_1", ts_q[1].w0, 32'd132);
      chk("t1_w0_2", ts_q[2].w0, 32'd36);
      chk("t1_w0_3", ts_q[3].w0, 32'd68);
    end else chk("t1_event_queues", 32'(ws_q.size()), 4);
    run_box(9'd0, 9'd5, 32'd1, 32'd2, 32'd3, 19'd1, 19'd1, 19'd1, 24'd1, 24'd1, 24'd1,
            32'h2000, 16'd64, 0, 0, 1'b0);
    run_box(9'd3, 9'd1, 32'd10, 32'd20, 32'd30, 19'd2, 19'd3, 19'd4, 24'd1, 24'd1, 24'd1,
            32'h4000, 16'd128, 0, 50, 1'b0);
    if (ts_cyc.size() >= 2 && ws_cyc.size() >= 2) begin
      chk("hold_ts2_overlaps", 32'(ts_cyc[1] - ws_cyc[0]), 2);
      chk("hold_ws2_delayed", 32'(ws_cyc[1] - ws_cyc[0] > 50), 1);
    end else chk("hold_event_queues", 32'(ws_cyc.size()), 3);
    run_box(9'd3, 9'd1, 32'h7FFFFFF0, 32'h80000010, 32'd0, 19'h40000, 19'h40000, 19'd0,
            24'd0, 24'd0, 24'd0, 32'h0, 16'd0, 0, 0, 1'b0);
    if (ts_q.size() == 3) begin
      chk("amin_w0_col1", ts_q[1].w0, 32'h7F7FFFF0);
      chk("amin_w0_col2", ts_q[2].w0, 32'h7EFFFFF0);
      chk("amin_w1_wrap", ts_q[1].w1, 32'h7F800010);
    end else chk("amin_event_queue", 32'(ts_q.size()), 3);
    run_box(9'd4, 9'd1, 32'd5, 32'd6, 32'd7, 19'd1, 19'd1, 19'd1, 24'd1, 24'd1, 24'd1,
            32'h8000, 16'd256, 2, 0, 1'b0);
    ts_q.delete(); ws_q.delete(); ts_cyc.delete(); ws_cyc.delete();
    ts_n = 0; ws_n = 0; abort_at = 0;
    @(negedge gpu_clk);
    drive_cmd(9'd3, 9'd3, 32'd1, 32'd2, 32'd3, 19'd1, 19'd1, 19'd1, 24'd1, 24'd1, 24'd1, 32'h100, 16'd32);
    cmd_if.cmd_valid = 1'b1;
    @(negedge gpu_clk);
    cmd_if.cmd_valid = 1'b0;
    k = 0;
    while (ts_n == 0 && k < 200) begin
      @(negedge gpu_clk);
      #1;
      k++;
    end
    chk("rst_mid_ts_seen", 32'(ts_n), 1);
    gpu_resetn = 1'b0;
    @(negedge gpu_clk);
    chk("rst_mid_ready", 32'(cmd_if.cmd_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_tile_start", 32'(tile_start), 0);
    chk("rst_mid_write_start", 32'(write_start), 0);
    chk("rst_mid_box_done", 32'(box_done), 0);
    chk("rst_mid_w0", w0_out, 0);
    chk("rst_mid_addr", wr_addr_out, 0);
    chk("rst_mid_tiles_written", 32'(tiles_written), 0);
    @(negedge gpu_clk);
    gpu_resetn = 1'b1;
    run_box(9'd2, 9'd3, 32'd1000, -32'sd1000, 32'd0, 19'd100, -19'sd100, 19'd7, 24'd50, -24'sd50, 24'd9,
            32'h10000, 16'd1280, 0, 0, 1'b0);
    repeat (10) begin
      rtx = 9'($urandom_range(1, 4));
      rty = 9'($urandom_range(1, 3));
      rlat = $urandom_range(1, 5);
      rd_len = $urandom_range(1, 6);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rtx) * int'(rty))) : 0;
      run_box(rtx, rty, $urandom, $urandom, $urandom, 19'($urandom), 19'($urandom), 19'($urandom),
              24'($urandom), 24'($urandom), 24'($urandom), $urandom, 16'($urandom), ab, 0,
              1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
